// File: rtl/lza_operand_pipe.sv
// Two-stage operand assembly and leading-zero count for the MAF normalisation path.
// Stage 1 builds the op0/op1 pair. Stage 2 adds the pair and counts leading zeros per lane.
module lza_operand_pipe #(
  parameter int AW  = 26,
  parameter int PW  = 48,
  parameter int OW  = 56,
  parameter int LZW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     mode,
  input  logic           d_pos,
  input  logic [AW-1:0]  addend,
  input  logic [PW-1:0]  sum,
  input  logic [PW:0]    carry,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OW-1:0]  out_op0,
  output logic [OW-1:0]  out_op1,
  output logic [OW-1:0]  out_sum,
  output logic [LZW-1:0] out_lzc_hi,
  output logic [LZW-1:0] out_lzc_lo,
  output logic           out_zero_hi,
  output logic           out_zero_lo,
  output logic [1:0]     out_mode
);

  localparam int L     = OW / 2;
  localparam int HA    = AW / 2;
  localparam int HS    = PW / 2;
  localparam int QS    = PW / 4;
  localparam int SH_FP = OW - AW - HS;
  localparam int SH_FN = OW - PW - 2;
  localparam int SH_DP = L - HA - QS;
  localparam int SH_DN = L - HS - 2;

  localparam logic [1:0] MODE_FULL = 2'b00;
  localparam logic [1:0] MODE_DUAL = 2'b01;

  function automatic logic [LZW-1:0] lzc_full(input logic [OW-1:0] v);
    logic [LZW-1:0] c;
    c = LZW'(OW);
    for (int i = 0; i < OW; i++) if (v[i]) c = LZW'(OW - 1 - i);
    return c;
  endfunction

  function automatic logic [LZW-1:0] lzc_lane(input logic [L-1:0] v);
    logic [LZW-1:0] c;
    c = LZW'(L);
    for (int i = 0; i < L; i++) if (v[i]) c = LZW'(L - 1 - i);
    return c;
  endfunction

  // Handshake: a beat moves from one place to the next on a clock edge where the
  // sender is valid and the receiver is ready; held outputs never change while
  // out_valid & !out_ready, and flush blocks every transfer for its cycle.
  logic s1_v, s2_v, s1_adv, s2_adv;
  assign s2_adv   = !s2_v || out_ready;
  assign s1_adv   = !s1_v || s2_adv;
  assign in_ready = s1_adv && !flush;

  // Operand assembly: each lane's pair is left-justified in its field.
  logic [OW-1:0] asm_op0, asm_op1;
  logic [L-1:0]  hi0, hi1, lo0, lo1;

  always_comb begin
    asm_op0 = '0;
    asm_op1 = '0;
    hi0 = '0;
    hi1 = '0;
    lo0 = '0;
    lo1 = '0;
    if (mode == MODE_FULL) begin
      if (d_pos) begin
        asm_op0 = OW'({addend, sum[PW-1:HS]}) << SH_FP;
        asm_op1 = OW'(carry[PW:HS]) << SH_FP;
      end else begin
        asm_op0 = OW'({addend[1:0], sum}) << SH_FN;
        asm_op1 = OW'(carry) << SH_FN;
      end
    end else if (mode == MODE_DUAL) begin
      if (d_pos) begin
        hi0 = L'({addend[AW-1:HA], sum[PW-1:PW-QS]}) << SH_DP;
        hi1 = L'(carry[PW:PW-QS]) << SH_DP;
        lo0 = L'({addend[HA-1:0], sum[HS-1:QS]}) << SH_DP;
        lo1 = L'(carry[HS-1:QS]) << SH_DP;
      end else begin
        hi0 = L'({addend[HA+1:HA], sum[PW-1:HS]}) << SH_DN;
        hi1 = L'(carry[PW:HS]) << SH_DN;
        lo0 = L'({addend[1:0], sum[HS-1:0]}) << SH_DN;
        lo1 = L'(carry[HS-1:0]) << SH_DN;
      end
      asm_op0 = {hi0, lo0};
      asm_op1 = {hi1, lo1};
    end
  end

  logic [1:0]    s1_mode;
  logic [OW-1:0] s1_op0, s1_op1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_mode <= '0;
      s1_op0  <= '0;
      s1_op1  <= '0;
    end else begin
      if (flush)       s1_v <= 1'b0;
      else if (s1_adv) s1_v <= in_valid;
      if (in_valid && in_ready) begin
        s1_mode <= mode;
        s1_op0  <= asm_op0;
        s1_op1  <= asm_op1;
      end
    end
  end

  // Stage 2: the DUAL adds are split so no carry crosses the lane boundary.
  logic [OW-1:0]  full_sum, nxt_sum;
  logic [L-1:0]   hi_sum, lo_sum;
  logic [LZW-1:0] nxt_lzc_hi, nxt_lzc_lo;
  logic           nxt_zero_hi, nxt_zero_lo;

  always_comb begin
    full_sum    = s1_op0 + s1_op1;
    hi_sum      = s1_op0[OW-1:L] + s1_op1[OW-1:L];
    lo_sum      = s1_op0[L-1:0] + s1_op1[L-1:0];
    nxt_sum     = full_sum;
    nxt_lzc_hi  = lzc_full(full_sum);
    nxt_lzc_lo  = '0;
    nxt_zero_hi = (full_sum == '0);
    nxt_zero_lo = 1'b0;
    if (s1_mode == MODE_DUAL) begin
      nxt_sum     = {hi_sum, lo_sum};
      nxt_lzc_hi  = lzc_lane(hi_sum);
      nxt_lzc_lo  = lzc_lane(lo_sum);
      nxt_zero_hi = (hi_sum == '0);
      nxt_zero_lo = (lo_sum == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v        <= 1'b0;
      out_op0     <= '0;
      out_op1     <= '0;
      out_sum     <= '0;
      out_lzc_hi  <= '0;
      out_lzc_lo  <= '0;
      out_zero_hi <= 1'b0;
      out_zero_lo <= 1'b0;
      out_mode    <= '0;
    end else begin
      if (flush)       s2_v <= 1'b0;
      else if (s2_adv) s2_v <= s1_v;
      if (s1_v && s2_adv && !flush) begin
        out_op0     <= s1_op0;
        out_op1     <= s1_op1;
        out_sum     <= nxt_sum;
        out_lzc_hi  <= nxt_lzc_hi;
        out_lzc_lo  <= nxt_lzc_lo;
        out_zero_hi <= nxt_zero_hi;
        out_zero_lo <= nxt_zero_lo;
        out_mode    <= s1_mode;
      end
    end
  end

  assign out_valid = s2_v;

endmodule

// File: tb/tb_lza_operand_pipe.sv
// Bench for lza_operand_pipe: directed cases, back-pressure, flush/reset and a
// randomized stream scored against a behavioural model of the operand rules.
module tb_lza_operand_pipe;

  localparam int AW  = 26;
  localparam int PW  = 48;
  localparam int CW  = PW + 1;
  localparam int OW  = 56;
  localparam int LZW = 6;
  localparam int L   = OW / 2;

  typedef struct packed {
    logic [1:0]    mode;
    logic          d_pos;
    logic [AW-1:0] addend;
    logic [PW-1:0] sum;
    logic [CW-1:0] carry;
  } beat_t;

  typedef struct packed {
    logic [1:0]     mode;
    logic [OW-1:0]  op0;
    logic [OW-1:0]  op1;
    logic [OW-1:0]  sum;
    logic [LZW-1:0] lzc_hi;
    logic [LZW-1:0] lzc_lo;
    logic           zero_hi;
    logic           zero_lo;
  } res_t;

  logic           clk;
  logic           rst_n;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     mode;
  logic           d_pos;
  logic [AW-1:0]  addend;
  logic [PW-1:0]  sum;
  logic [CW-1:0]  carry;
  logic           out_valid;
  logic           out_ready;
  logic [OW-1:0]  out_op0;
  logic [OW-1:0]  out_op1;
  logic [OW-1:0]  out_sum;
  logic [LZW-1:0] out_lzc_hi;
  logic [LZW-1:0] out_lzc_lo;
  logic           out_zero_hi;
  logic           out_zero_lo;
  logic [1:0]     out_mode;

  int   checks   = 0;
  int   failures = 0;
  res_t exp_q[$];

  lza_operand_pipe #(.AW(AW), .PW(PW), .OW(OW), .LZW(LZW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .d_pos(d_pos), .addend(addend), .sum(sum), .carry(carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op0(out_op0), .out_op1(out_op1), .out_sum(out_sum),
    .out_lzc_hi(out_lzc_hi), .out_lzc_lo(out_lzc_lo),
    .out_zero_hi(out_zero_hi), .out_zero_lo(out_zero_lo),
    .out_mode(out_mode)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model
  function automatic logic [63:0] msk(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic int lzc_model(input logic [63:0] v, input int fw);
    for (int i = fw - 1; i >= 0; i--) if (v[i]) return fw - 1 - i;
    return fw;
  endfunction

  function automatic void lane_model(input int fw, input int a, input int s,
                                     input logic [63:0] av, input logic [63:0] sv,
                                     input logic [63:0] cv, input logic dp,
                                     output logic [63:0] o0, output logic [63:0] o1);
    if (dp) begin
      o0 = ((av << (s / 2)) + (sv >> (s / 2))) << (fw - a - s / 2);
      o1 = (cv >> (s / 2)) << (fw - a - s / 2);
    end else begin
      o0 = (((av & 64'd3) << s) + sv) << (fw - s - 2);
      o1 = cv << (fw - s - 2);
    end
  endfunction

  function automatic res_t model(input beat_t b);
    res_t r;
    logic [63:0] h0, h1, l0, l1, hs, ls, o0, o1, s;
    r = '0;
    r.mode = b.mode;
    case (b.mode)
      2'b00: begin
        lane_model(OW, AW, PW, 64'(b.addend), 64'(b.sum), 64'(b.carry), b.d_pos, o0, o1);
        s = (o0 + o1) & msk(OW);
        r.op0 = o0[OW-1:0];
        r.op1 = o1[OW-1:0];
        r.sum = s[OW-1:0];
        r.lzc_hi = LZW'(lzc_model(s, OW));
        r.zero_hi = (s == 0);
      end
      2'b01: begin
        lane_model(L, AW - AW / 2, PW / 2, 64'(b.addend) >> (AW / 2), 64'(b.sum) >> (PW / 2),
                   64'(b.carry) >> (PW / 2), b.d_pos, h0, h1);
        lane_model(L, AW / 2, PW / 2, 64'(b.addend) & msk(AW / 2), 64'(b.sum) & msk(PW / 2),
                   64'(b.carry) & msk(PW / 2), b.d_pos, l0, l1);
        hs = (h0 + h1) & msk(L);
        ls = (l0 + l1) & msk(L);
        o0 = (h0 << L) | l0;
        o1 = (h1 << L) | l1;
        s  = (hs << L) | ls;
        r.op0 = o0[OW-1:0];
        r.op1 = o1[OW-1:0];
        r.sum = s[OW-1:0];
        r.lzc_hi = LZW'(lzc_model(hs, L));
        r.lzc_lo = LZW'(lzc_model(ls, L));
        r.zero_hi = (hs == 0);
        r.zero_lo = (ls == 0);
      end
      default: begin
        r.lzc_hi = LZW'(OW);
        r.zero_hi = 1'b1;
      end
    endcase
    return r;
  endfunction

  function automatic res_t observe();
    res_t r;
    r.mode = out_mode;
    r.op0 = out_op0;
    r.op1 = out_op1;
    r.sum = out_sum;
    r.lzc_hi = out_lzc_hi;
    r.lzc_lo = out_lzc_lo;
    r.zero_hi = out_zero_hi;
    r.zero_lo = out_zero_lo;
    return r;
  endfunction

  function automatic beat_t rand_beat(input logic [1:0] m);
    beat_t b;
    b.mode   = m;
    b.d_pos  = 1'($urandom_range(0, 1));
    b.addend = AW'({$urandom, $urandom});
    b.sum    = PW'({$urandom, $urandom});
    b.carry  = CW'({$urandom, $urandom});
    return b;
  endfunction

  // Driver tasks
  task automatic apply_beat(input beat_t b);
    mode   = b.mode;
    d_pos  = b.d_pos;
    addend = b.addend;
    sum    = b.sum;
    carry  = b.carry;
  endtask

  task automatic send_and_wait(input beat_t b, output res_t got, output int lat);
    int guard;
    @(negedge clk);
    apply_beat(b);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 10) begin
      @(negedge clk);
      #1;
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    apply_beat(rand_beat(2'b00));
    lat = -1;
    got = '0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (out_valid) begin
        got = observe();
        lat = k;
        break;
      end
    end
  endtask

  task automatic fill_two();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      apply_beat(rand_beat(2'($urandom_range(0, 1))));
      in_valid  = 1'b1;
      out_ready = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    apply_beat(rand_beat(2'b00));
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || observe() !== res_t'('0)) begin
      failures++;
      $display("FAIL reset_held got=%b/%h exp=0/0", out_valid, observe());
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got=in_ready:%b out_valid:%b exp=1,0", in_ready, out_valid);
    end
  endtask

  task automatic test_full_dpos();
    beat_t b; res_t got; int lat;
    b = '0; b.mode = 2'b00; b.d_pos = 1'b1; b.addend = 26'h2000000;
    send_and_wait(b, got, lat);
    checks++;
    if (lat != 2) begin failures++; $display("FAIL full_dpos_latency got=%0d exp=2", lat); end
    checks++;
    if (got.sum !== 56'h80000000000000 || got.op0[OW-1] !== 1'b1 || got.lzc_hi !== 6'd0 || got.zero_hi !== 1'b0) begin
      failures++;
      $display("FAIL full_dpos_const got=%h exp=sum 80000000000000 lzc 0", got);
    end
    checks++;
    if (got !== model(b)) begin failures++; $display("FAIL full_dpos_model got=%h exp=%h", got, model(b)); end
  endtask

  task automatic test_full_dneg();
    beat_t b; res_t got; int lat;
    b = '0; b.mode = 2'b00; b.d_pos = 1'b0; b.sum = 48'h1;
    send_and_wait(b, got, lat);
    checks++;
    if (lat != 2 || got.op0 !== 56'h40 || got.op1 !== 56'h0 || got.lzc_hi !== 6'd49) begin
      failures++;
      $display("FAIL full_dneg_const got=lat %0d res %h exp=op0 40 op1 0 lzc 49", lat, got);
    end
    checks++;
    if (got !== model(b)) begin failures++; $display("FAIL full_dneg_model got=%h exp=%h", got, model(b)); end
  endtask

  task automatic test_dual();
    beat_t b; res_t got; int lat;
    b = '0; b.mode = 2'b01; b.d_pos = 1'b1; b.addend = 26'h1000;
    send_and_wait(b, got, lat);
    checks++;
    if (lat != 2 || got.lzc_lo !== 6'd0 || got.zero_lo !== 1'b0 || got.lzc_hi !== 6'd28 || got.zero_hi !== 1'b1) begin
      failures++;
      $display("FAIL dual_const got=lat %0d res %h exp=lzc_lo 0 zero_lo 0 lzc_hi 28 zero_hi 1", lat, got);
    end
    checks++;
    if (got !== model(b)) begin failures++; $display("FAIL dual_model got=%h exp=%h", got, model(b)); end
    for (int i = 0; i < 4; i++) begin
      b = rand_beat(2'b01);
      send_and_wait(b, got, lat);
      checks++;
      if (lat != 2 || got !== model(b)) begin
        failures++;
        $display("FAIL dual_random got=lat %0d res %h exp=%h", lat, got, model(b));
      end
    end
  endtask

  task automatic test_zero();
    beat_t b; res_t got; int lat;
    for (int i = 0; i < 4; i++) begin
      b = rand_beat((i % 2 == 0) ? 2'b11 : 2'b10);
      send_and_wait(b, got, lat);
      checks++;
      if (lat != 2 || got.op0 !== '0 || got.op1 !== '0 || got.sum !== '0 || got.lzc_hi !== 6'd56 ||
          got.zero_hi !== 1'b1 || got.lzc_lo !== 6'd0 || got.zero_lo !== 1'b0 || got.mode !== b.mode) begin
        failures++;
        $display("FAIL zero_mode got=lat %0d res %h exp=zeros lzc_hi 56 mode %b", lat, got, b.mode);
      end
    end
  endtask

  task automatic test_back_pressure();
    beat_t bs[4]; res_t held, e; int nxt, delivered;
    exp_q.delete();
    for (int i = 0; i < 4; i++) bs[i] = rand_beat(2'($urandom_range(0, 1)));
    nxt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      apply_beat(bs[nxt]);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      #1;
      if (in_ready) begin exp_q.push_back(model(bs[nxt])); nxt++; end
    end
    checks++;
    if (nxt != 2 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept got=%0d in_ready %b exp=2 in_ready 0", nxt, in_ready);
    end
    held = observe();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || observe() !== held) begin
      failures++;
      $display("FAIL bp_hold got=%b %h exp=1 %h", out_valid, observe(), held);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    delivered = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL bp_extra got=%h exp=nothing", observe());
        end else begin
          e = exp_q.pop_front();
          if (observe() !== e) begin failures++; $display("FAIL bp_order got=%h exp=%h", observe(), e); end
        end
        delivered++;
      end
      @(negedge clk);
    end
    checks++;
    if (delivered != 2) begin failures++; $display("FAIL bp_count got=%0d exp=2", delivered); end
  endtask

  task automatic test_random_stream();
    beat_t b; res_t e; int drained;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      b = rand_beat(2'($urandom_range(0, 3)));
      apply_beat(b);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (in_ready !== ((exp_q.size() < 2) || out_ready)) begin
        failures++;
        $display("FAIL stream_ready got=%b exp=%b inflight %0d", in_ready, (exp_q.size() < 2) || out_ready, exp_q.size());
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL stream_extra got=%h exp=nothing", observe());
        end else begin
          e = exp_q.pop_front();
          if (observe() !== e) begin failures++; $display("FAIL stream_data got=%h exp=%h", observe(), e); end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(b));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drained = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (observe() !== e) begin failures++; $display("FAIL stream_drain got=%h exp=%h", observe(), e); end
        drained++;
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL stream_lost got=%0d exp=0 left", exp_q.size()); end
  endtask

  task automatic test_flush_reset();
    beat_t b; res_t got; int lat; logic seen;
    fill_two();
    #1;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_prefill got=%b exp=1", out_valid); end
    flush    = 1'b1;
    in_valid = 1'b1;
    apply_beat(rand_beat(2'b00));
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_clear got=%b exp=0", out_valid); end
    seen = 1'b0;
    repeat (3) begin @(negedge clk); #1; seen = seen | out_valid; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL flush_ghost got=%b exp=0", seen); end
    b = rand_beat(2'b01);
    send_and_wait(b, got, lat);
    checks++;
    if (lat != 2 || got !== model(b)) begin
      failures++;
      $display("FAIL flush_after got=lat %0d res %h exp=lat 2 res %h", lat, got, model(b));
    end
    fill_two();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || observe() !== res_t'('0)) begin
      failures++;
      $display("FAIL reset_async got=%b %h exp=0 0", out_valid, observe());
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_release got=%b %b exp=1 0", in_ready, out_valid);
    end
    b = rand_beat(2'b00);
    send_and_wait(b, got, lat);
    checks++;
    if (lat != 2 || got !== model(b)) begin
      failures++;
      $display("FAIL reset_after got=lat %0d res %h exp=lat 2 res %h", lat, got, model(b));
    end
  endtask

  initial begin
    test_reset();
    test_full_dpos();
    test_full_dneg();
    test_dual();
    test_zero();
    test_back_pressure();
    test_random_stream();
    test_flush_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
